// File: rtl/cpu_pkg.sv
// cpu_pkg: shared divider state encoding, iteration count and divide-by-zero quotient
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_e;
  localparam int DIV_ITERS = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step; ports rem_i/dvd_i/dsr_i in, next rem_o and dvd_o (quotient bit shifted into dvd_o[0]) out
module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] dvd_i,
  input  logic [31:0] dsr_i,
  output logic [31:0] rem_o,
  output logic [31:0] dvd_o
);
  logic [32:0] sh;
  logic [32:0] trial;
  logic        q;
  assign sh    = {rem_i, dvd_i[31]};
  assign trial = sh - {1'b0, dsr_i};
  assign q     = sh >= {1'b0, dsr_i};
  assign rem_o = q ? trial[31:0] : sh[31:0];
  assign dvd_o = {dvd_i[30:0], q};
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit signed/unsigned divider; in clk/reset/div_en/div_signed/div_src1/div_src2, out div_busy/div_done/div_result={rem,quo}; DIV_EARLY_OUT_EN skips CALC for zero divisor or |dividend|<|divisor|
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               div_en,
  input  logic               div_signed,
  input  logic [WIDTH-1:0]   div_src1,
  input  logic [WIDTH-1:0]   div_src2,
  output logic               div_busy,
  output logic               div_done,
  output logic [2*WIDTH-1:0] div_result
);
  div_state_e         state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d, dvd_q, dvd_d, dsr_q, dsr_d;
  logic [WIDTH-1:0]   abs1, abs2, step_rem, step_dvd;
  logic               qs_q, qs_d, rs_q, rs_d, dz_q, dz_d, done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               accept, early;
  assign abs1   = (div_signed && div_src1[WIDTH-1]) ? -div_src1 : div_src1;
  assign abs2   = (div_signed && div_src2[WIDTH-1]) ? -div_src2 : div_src2;
  assign accept = (state_q == IDLE) && div_en;
`ifdef DIV_EARLY_OUT_EN
  assign early  = (div_src2 == '0) || (abs1 < abs2);
`else
  assign early  = 1'b0;
`endif
  div_step u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .dvd_o (step_dvd)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      qs_q     <= 1'b0;
      rs_q     <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      qs_q     <= qs_d;
      rs_q     <= rs_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (accept ? (early ? FIX : CALC) : IDLE) :
              state_q == CALC ? (cnt_q == 5'(DIV_ITERS - 1) ? FIX : CALC) : IDLE;
  end
  // Early-out preloads rem with |dividend| and a zero quotient so FIX's sign fix yields {dividend, 0}.
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    qs_d     = qs_q;
    rs_d     = rs_q;
    dz_d     = dz_q;
    result_d = result_q;
    done_d   = state_q == FIX;
    if (accept) begin
      cnt_d = '0;
      rem_d = early ? abs1 : '0;
      dvd_d = early ? '0 : abs1;
      dsr_d = abs2;
      qs_d  = div_signed && (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
      rs_d  = div_signed && div_src1[WIDTH-1];
      dz_d  = div_src2 == '0;
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + 5'd1;
      rem_d = step_rem;
      dvd_d = step_dvd;
    end else if (state_q == FIX) begin
      result_d = {rs_q ? -rem_q : rem_q, dz_q ? DIV_ZERO_Q : (qs_q ? -dvd_q : dvd_q)};
    end
  end
  assign div_busy   = (state_q != IDLE) || div_en;
  assign div_done   = done_q;
  assign div_result = result_q;
endmodule
